// File: rtl/vtw_scan_fail_capture.sv
// Scan fail capture: masked per-lane compare, saturating counters, fail-record FIFO, pass/done verdict.
// Optional auto-stop after STOP_LIMIT fail records is enabled by defining VTW_FAIL_STOP_EN.
module vtw_scan_fail_capture #(
   parameter int LANES      = 4,
   parameter int CYCLE_W    = 32,
   parameter int CNT_W      = 32,
   parameter int DEPTH      = 16,
   parameter int STOP_LIMIT = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       pat_start,
   input  logic                       pat_end,
   input  logic                       strobe_valid,
   input  logic [CYCLE_W-1:0]         cycle_number,
   input  logic [LANES-1:0]           scan_out,
   input  logic [LANES-1:0]           expected,
   input  logic [LANES-1:0]           compare_en,
   input  logic                       rd_ready,
   output logic                       rd_valid,
   output logic [CYCLE_W-1:0]         rd_cycle,
   output logic [LANES-1:0]           rd_lanes,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic [CNT_W-1:0]           fail_number,
   output logic [CNT_W-1:0]           compare_number,
   output logic                       overflow,
   output logic                       busy,
   output logic                       done,
   output logic                       pass
`ifdef VTW_FAIL_STOP_EN
   ,
   output logic                       stopped
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int PW = $clog2(LANES + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic [PW-1:0] popcount(input logic [LANES-1:0] v);
      logic [PW-1:0] c;
      c = '0;
      for (int i = 0; i < LANES; i++) begin
         c = c + PW'(v[i]);
      end
      return c;
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [PW-1:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + (CNT_W+1)'(b);
      if (s[CNT_W]) begin
         return '1;
      end else begin
         return s[CNT_W-1:0];
      end
   endfunction

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    fail_q, fail_d;
   logic [CNT_W-1:0]    cmp_q, cmp_d;
   logic                ovf_q, ovf_d;
   logic [AW-1:0]       wr_q, wr_d;
   logic [AW-1:0]       rd_q, rd_d;
   logic [LW-1:0]       cnt_q, cnt_d;
   logic [CYCLE_W-1:0]  mem_cyc_q   [DEPTH];
   logic [LANES-1:0]    mem_lanes_q [DEPTH];

   logic [LANES-1:0]    fail_lanes_s;
   logic                cmp_act_s;
   logic                push_req_s;
   logic                push_s;
   logic                pop_s;
   logic                full_s;

`ifdef VTW_FAIL_STOP_EN
   localparam int REC_W = $clog2(STOP_LIMIT + 1);
   logic [REC_W-1:0]    rec_q, rec_d;
   logic                stopped_q, stopped_d;
`endif

   assign fail_lanes_s = (scan_out ^ expected) & compare_en;
   assign cmp_act_s    = (state_q == ST_RUN) && strobe_valid;
   assign push_req_s   = cmp_act_s && (fail_lanes_s != '0);
   assign full_s       = (cnt_q == LW'(DEPTH));
   assign pop_s        = (cnt_q != '0) && rd_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_s       = push_req_s && (!full_s || pop_s);

   // Next-state, counter and FIFO pointer logic.
   always_comb begin
      state_d = state_q;
      fail_d  = fail_q;
      cmp_d   = cmp_q;
      ovf_d   = ovf_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q + LW'(push_s) - LW'(pop_s);
`ifdef VTW_FAIL_STOP_EN
      rec_d     = rec_q;
      stopped_d = stopped_q;
`endif
      if (cmp_act_s) begin
         fail_d = sat_add(fail_q, popcount(fail_lanes_s));
         cmp_d  = sat_add(cmp_q, popcount(compare_en));
      end else begin
         fail_d = fail_q;
         cmp_d  = cmp_q;
      end
      if (push_req_s && !push_s) begin
         ovf_d = 1'b1;
      end else begin
         ovf_d = ovf_q;
      end
      if (push_s) begin
         wr_d = wr_q + AW'(1);
      end else begin
         wr_d = wr_q;
      end
      if (pop_s) begin
         rd_d = rd_q + AW'(1);
      end else begin
         rd_d = rd_q;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (pat_start) begin
               state_d = ST_RUN;
               fail_d  = '0;
               cmp_d   = '0;
               ovf_d   = 1'b0;
               wr_d    = '0;
               rd_d    = '0;
               cnt_d   = '0;
`ifdef VTW_FAIL_STOP_EN
               rec_d     = '0;
               stopped_d = 1'b0;
`endif
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN: begin
            if (pat_end) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_RUN;
            end
`ifdef VTW_FAIL_STOP_EN
            // Dropped records count toward the limit as well as accepted ones.
            if (push_req_s) begin
               rec_d = rec_q + REC_W'(1);
               if ((rec_q + REC_W'(1)) == REC_W'(STOP_LIMIT)) begin
                  state_d   = ST_DRAIN;
                  stopped_d = 1'b1;
               end else begin
                  stopped_d = stopped_q;
               end
            end else begin
               rec_d = rec_q;
            end
`endif
         end
         ST_DRAIN: begin
            if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counters and FIFO control registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         fail_q  <= '0;
         cmp_q   <= '0;
         ovf_q   <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
`ifdef VTW_FAIL_STOP_EN
         rec_q     <= '0;
         stopped_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         fail_q  <= fail_d;
         cmp_q   <= cmp_d;
         ovf_q   <= ovf_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
`ifdef VTW_FAIL_STOP_EN
         rec_q     <= rec_d;
         stopped_q <= stopped_d;
`endif
      end
   end

   // Fail-record storage.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_cyc_q[i]   <= '0;
            mem_lanes_q[i] <= '0;
         end
      end else if (push_s) begin
         mem_cyc_q[wr_q]   <= cycle_number;
         mem_lanes_q[wr_q] <= fail_lanes_s;
      end
   end

   assign rd_valid       = (cnt_q != '0);
   assign rd_cycle       = rd_valid ? mem_cyc_q[rd_q] : '0;
   assign rd_lanes       = rd_valid ? mem_lanes_q[rd_q] : '0;
   assign fifo_level     = cnt_q;
   assign fail_number    = fail_q;
   assign compare_number = cmp_q;
   assign overflow       = ovf_q;
   assign busy           = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done           = (state_q == ST_DONE);
   assign pass           = (state_q == ST_DONE) && (fail_q == '0);
`ifdef VTW_FAIL_STOP_EN
   assign stopped        = stopped_q;
`endif

endmodule

// File: tb/tb_vtw_scan_fail_capture.sv
// Directed bench for vtw_scan_fail_capture: vector table plus hand-written corner sequences.
module tb_vtw_scan_fail_capture;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        pat_start = 1'b0;
   logic        pat_end = 1'b0;
   logic        strobe_valid = 1'b0;
   logic [31:0] cycle_number = 32'd0;
   logic [3:0]  scan_out = 4'd0;
   logic [3:0]  expected = 4'd0;
   logic [3:0]  compare_en = 4'd0;
   logic        rd_ready = 1'b0;
   logic        rd_valid;
   logic [31:0] rd_cycle;
   logic [3:0]  rd_lanes;
   logic [4:0]  fifo_level;
   logic [31:0] fail_number;
   logic [31:0] compare_number;
   logic        overflow;
   logic        busy;
   logic        done;
   logic        pass;
`ifdef VTW_FAIL_STOP_EN
   logic        stopped;
`endif

   int n_vec = 0;
   int n_miss = 0;

   vtw_scan_fail_capture dut (
      .clock          (clock),
      .reset          (reset),
      .pat_start      (pat_start),
      .pat_end        (pat_end),
      .strobe_valid   (strobe_valid),
      .cycle_number   (cycle_number),
      .scan_out       (scan_out),
      .expected       (expected),
      .compare_en     (compare_en),
      .rd_ready       (rd_ready),
      .rd_valid       (rd_valid),
      .rd_cycle       (rd_cycle),
      .rd_lanes       (rd_lanes),
      .fifo_level     (fifo_level),
      .fail_number    (fail_number),
      .compare_number (compare_number),
      .overflow       (overflow),
      .busy           (busy),
      .done           (done),
      .pass           (pass)
`ifdef VTW_FAIL_STOP_EN
      ,
      .stopped        (stopped)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        sv;
      logic [31:0] cyc;
      logic [3:0]  so;
      logic [3:0]  ex;
      logic [3:0]  en;
      logic [31:0] e_fail;
      logic [31:0] e_cmp;
      logic [4:0]  e_lvl;
   } vec_t;

   vec_t vecs [7];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic strobe(input logic [31:0] cyc, input logic [3:0] so, input logic [3:0] ex,
                         input logic [3:0] en);
      strobe_valid = 1'b1;
      cycle_number = cyc;
      scan_out     = so;
      expected     = ex;
      compare_en   = en;
      tick();
      strobe_valid = 1'b0;
   endtask

   task automatic start_pattern();
      pat_start = 1'b1;
      tick();
      pat_start = 1'b0;
   endtask

   task automatic end_pattern();
      pat_end = 1'b1;
      tick();
      pat_end = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int k;
      k = 0;
      while (!done && k < 60) begin
         tick();
         k++;
      end
      check(name, {63'd0, done}, 64'd1);
   endtask

   initial begin
      int   rd_seen;
      int   exp_cyc;
      vecs[0] = '{1'b1, 32'd37, 4'b1010, 4'b0110, 4'b0111, 32'd1, 32'd3,  5'd1};
      vecs[1] = '{1'b0, 32'd38, 4'hF,    4'h0,    4'hF,    32'd1, 32'd3,  5'd1};
      vecs[2] = '{1'b1, 32'd39, 4'hF,    4'h0,    4'hF,    32'd5, 32'd7,  5'd2};
      vecs[3] = '{1'b1, 32'd40, 4'h5,    4'h5,    4'hF,    32'd5, 32'd11, 5'd2};
      vecs[4] = '{1'b1, 32'd41, 4'h3,    4'h0,    4'h0,    32'd5, 32'd11, 5'd2};
      vecs[5] = '{1'b1, 32'd42, 4'h1,    4'h0,    4'h1,    32'd6, 32'd12, 5'd3};
      vecs[6] = '{1'b1, 32'd43, 4'h8,    4'h0,    4'hC,    32'd7, 32'd14, 5'd4};

      // reset state
      tick();
      tick();
      @(negedge clock);
      reset = 1'b0;
      tick();
      check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
      check("rst_level", {59'd0, fifo_level}, 64'd0);
      check("rst_fail", {32'd0, fail_number}, 64'd0);
      check("rst_cmp", {32'd0, compare_number}, 64'd0);
      check("rst_flags", {60'd0, overflow, busy, done, pass}, 64'd0);

      // clean pass
      start_pattern();
      check("clean_busy", {63'd0, busy}, 64'd1);
      rd_ready = 1'b1;
      rd_seen  = 0;
      for (int i = 0; i < 100; i++) begin
         strobe(32'(i), 4'(i), 4'(i), 4'hF);
         if (rd_valid) rd_seen++;
      end
      end_pattern();
      if (rd_valid) rd_seen++;
      tick();
      check("clean_done", {62'd0, done, pass}, 64'd3);
      check("clean_cmp", {32'd0, compare_number}, 64'd400);
      check("clean_fail", {32'd0, fail_number}, 64'd0);
      check("clean_rd_seen", 64'(rd_seen), 64'd0);

      // table vectors with reader stalled
      start_pattern();
      rd_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         strobe_valid = vecs[i].sv;
         cycle_number = vecs[i].cyc;
         scan_out     = vecs[i].so;
         expected     = vecs[i].ex;
         compare_en   = vecs[i].en;
         tick();
         strobe_valid = 1'b0;
         check($sformatf("vec%0d_fail", i), {32'd0, fail_number}, {32'd0, vecs[i].e_fail});
         check($sformatf("vec%0d_cmp", i), {32'd0, compare_number}, {32'd0, vecs[i].e_cmp});
         check($sformatf("vec%0d_lvl", i), {59'd0, fifo_level}, {59'd0, vecs[i].e_lvl});
         if (i == 0) begin
            check("masked_head_cyc", {32'd0, rd_cycle}, 64'd37);
            check("masked_head_lanes", {60'd0, rd_lanes}, 64'd4);
         end
      end
      end_pattern();
      tick();
      check("drain_wait", {62'd0, busy, done}, 64'd2);
      rd_ready = 1'b1;
      check("rec0", {28'd0, rd_cycle, rd_lanes}, {28'd0, 32'd37, 4'h4});
      tick();
      check("rec1", {28'd0, rd_cycle, rd_lanes}, {28'd0, 32'd39, 4'hF});
      tick();
      check("rec2", {28'd0, rd_cycle, rd_lanes}, {28'd0, 32'd42, 4'h1});
      tick();
      check("rec3", {28'd0, rd_cycle, rd_lanes}, {28'd0, 32'd43, 4'h8});
      tick();
      wait_done("table_done");
      check("table_pass", {63'd0, pass}, 64'd0);

      // overflow under backpressure
      start_pattern();
      rd_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         strobe(32'(100 + i), 4'h1, 4'h0, 4'h1);
         if (i == 15) begin
            check("ovf_at_full", {63'd0, overflow}, 64'd0);
            check("lvl_at_full", {59'd0, fifo_level}, 64'd16);
         end
      end
      check("ovf_level", {59'd0, fifo_level}, 64'd16);
      check("ovf_flag", {63'd0, overflow}, 64'd1);
      check("ovf_fail", {32'd0, fail_number}, 64'd20);
      end_pattern();
      rd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("ovf_rec%0d", i), {32'd0, rd_cycle}, 64'(100 + i));
         tick();
      end
      wait_done("ovf_done");
      check("ovf_sticky", {63'd0, overflow}, 64'd1);

      // full FIFO with simultaneous push and pop
      start_pattern();
      rd_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         strobe(32'(200 + i), 4'h2, 4'h0, 4'h2);
      end
      check("pp_full", {59'd0, fifo_level}, 64'd16);
      rd_ready = 1'b1;
      strobe(32'd216, 4'h2, 4'h0, 4'h2);
      rd_ready = 1'b0;
      check("pp_level", {59'd0, fifo_level}, 64'd16);
      check("pp_ovf", {63'd0, overflow}, 64'd0);
      check("pp_head", {32'd0, rd_cycle}, 64'd201);
      end_pattern();
      rd_ready = 1'b1;
      exp_cyc  = 201;
      for (int k = 0; k < 40 && !done; k++) begin
         if (rd_valid) begin
            check("pp_order", {32'd0, rd_cycle}, 64'(exp_cyc));
            exp_cyc++;
         end
         tick();
      end
      check("pp_done", {63'd0, done}, 64'd1);
      check("pp_count", 64'(exp_cyc), 64'd217);

      // asynchronous reset mid-run
      start_pattern();
      rd_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         strobe(32'(300 + i), 4'h4, 4'h0, 4'hF);
      end
      check("rr_level", {59'd0, fifo_level}, 64'd5);
      #2;
      reset = 1'b1;
      #1;
      check("rr_zero", {rd_valid, fifo_level, overflow, busy, done, pass, 54'd0}, 64'd0);
      check("rr_cnt", {fail_number, compare_number}, 64'd0);
      @(negedge clock);
      reset = 1'b0;
      tick();
      start_pattern();
      check("rr_restart", {58'd0, busy, fifo_level}, {58'd0, 1'b1, 5'd0});
      strobe(32'd400, 4'h9, 4'h9, 4'hF);
      check("rr_clean", {fail_number, compare_number}, {32'd0, 32'd4});

`ifdef VTW_FAIL_STOP_EN
      end_pattern();
      wait_done("stop_pre");
      start_pattern();
      rd_ready = 1'b0;
      for (int i = 0; i < 12; i++) begin
         strobe(32'(500 + i), 4'h1, 4'h0, 4'h1);
      end
      check("stop_flag", {63'd0, stopped}, 64'd1);
      check("stop_level", {59'd0, fifo_level}, 64'd8);
      check("stop_fail", {32'd0, fail_number}, 64'd8);
      check("stop_cmp", {32'd0, compare_number}, 64'd8);
      rd_ready = 1'b1;
      wait_done("stop_done");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/vtw_scan_fail_capture.md
Name: vtw_scan_fail_capture

Overview:
- Synthesizable compare-and-log stage that sits directly downstream of the DUT scan outputs.
- Per strobe, compares the 4 scan_out lanes against tester expected data under a per-lane compare mask.
- Counts compares and fails, and buffers per-cycle fail records in a FIFO drained by a valid/ready reader.
- Supplies the fail_number and compare_number values consumed by the logging layer, and a pass/done verdict at pattern end.

Parameters:
LANES, 4, number of scan_out lanes compared per strobe
CYCLE_W, 32, width of cycle_number tag stored per fail record
CNT_W, 32, width of fail/compare counters (saturating)
DEPTH, 16, fail-record FIFO depth (power of 2, >=2)
STOP_LIMIT, 8, fail-record count that triggers auto-stop (used only with VTW_FAIL_STOP_EN)

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
pat_start  in  1  one-cycle pulse: begin pattern (accepted in IDLE or DONE)
pat_end  in  1  one-cycle pulse: last strobe delivered (accepted in RUN)
strobe_valid  in  1  compare strobe this cycle
cycle_number  in  CYCLE_W  tester cycle tag for this strobe
scan_out  in  LANES  DUT scan_out{LANES-1..0}
expected  in  LANES  tester expected values
compare_en  in  LANES  per-lane compare mask (0 = don't care)
rd_ready  in  1  reader accepts head record
rd_valid  out  1  FIFO non-empty
rd_cycle  out  CYCLE_W  head record cycle tag
rd_lanes  out  LANES  head record failing-lane bitmap
fifo_level  out  $clog2(DEPTH)+1  records held
fail_number  out  CNT_W  total failing lane-compares
compare_number  out  CNT_W  total enabled lane-compares
overflow  out  1  sticky: a fail record was dropped while FIFO full
busy  out  1  state is RUN or DRAIN
done  out  1  state is DONE
pass  out  1  valid when done: fail_number==0

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE.
- States:
  - IDLE: pat_start -> RUN; counters, overflow and FIFO cleared on the transition.
  - RUN: processes strobes; pat_end -> DRAIN.
  - DRAIN: strobes ignored; FIFO empty -> DONE.
  - DONE: holds done=1 and pass; pat_start -> RUN with the same clearing as from IDLE.
  - pat_start in RUN/DRAIN and pat_end outside RUN are ignored.
- Compare (RUN only, strobe_valid=1):
  - fail_lanes = (scan_out ^ expected) & compare_en.
  - compare_number += popcount(compare_en); fail_number += popcount(fail_lanes).
  - Both counters saturate at 2^CNT_W-1.
  - Counters visible 1 cycle after the strobe.
- Record push: when fail_lanes != 0, push {cycle_number, fail_lanes}.
  - If the FIFO is full and no pop occurs the same cycle: record dropped, overflow set (sticky until next pat_start); counters still updated.
- A strobe on the same cycle as pat_end is processed before entering DRAIN.
- FIFO: pop when rd_valid && rd_ready.
  - Simultaneous push+pop when full: both occur, level unchanged, no overflow.
  - Simultaneous push+pop when empty: push accepted, rd_valid=1 next cycle (no fall-through).
  - rd_cycle/rd_lanes are registered head entries, stable while rd_valid && !rd_ready.
  - Pointers wrap modulo DEPTH.
- Reads may continue in any state; DONE is reached only after the FIFO is fully drained.
- Reset mid-operation: immediate return to IDLE, FIFO flushed, counters and flags zeroed.
- pass = done && (fail_number==0); overflow does not affect pass.

Optional Feature:
VTW_FAIL_STOP_EN
- Defined:
  - A record counter counts accepted plus dropped fail records.
  - When it reaches STOP_LIMIT in RUN, the state moves to DRAIN on the next cycle as if pat_end had pulsed, and sticky output port stopped (1 bit) is asserted.
  - Strobes after the limiting strobe are not compared or counted.
- Undefined: no stopped port, no record counter; RUN continues until pat_end regardless of fail count.

Test Plan:
- Clean pass: pat_start, 100 strobes with compare_en=4'hF and scan_out==expected, pat_end, rd_ready=1 -> compare_number=400, fail_number=0, rd_valid never 1, done=1 and pass=1 within 2 cycles of pat_end.
- Masked fail: strobe cycle_number=37, scan_out=4'b1010, expected=4'b0110, compare_en=4'b0111 -> fail_lanes=4'b0100, fail_number=1, compare_number=3, head record {37,4'b0100}, pass=0 at done.
- Overflow/backpressure: rd_ready=0, 20 failing strobes (DEPTH=16) -> fifo_level=16, overflow=1, fail_number counts all 20; release rd_ready -> 16 records in cycle order, then DONE after pat_end.
- Full push+pop: FIFO at 16, rd_ready=1 with failing strobe same cycle -> level stays 16, overflow stays 0.
- Async reset mid-RUN: assert reset between clock edges with 5 records queued -> outputs 0 immediately, state IDLE, next pat_start starts clean.
- VTW_FAIL_STOP_EN, STOP_LIMIT=8: 12 consecutive failing strobes -> stopped=1, exactly 8 records, the 9th-12th strobes not counted, done after drain.
